// File: rtl/pipe_ctrl_unit_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit_if
// Bundles the instruction/control signals exchanged between the pipeline
// controller and the surrounding datapath.
//   master : datapath side; drives inst/eq/hold, receives the control outputs
//   slave  : controller side; receives inst/eq/hold, drives the control outputs
// Signals:
//   inst, eq, hold                          ID instruction, rs==rt, freeze
//   EX_alusrc, EX_regdst, EX_aluop          ID/EX stage controls
//   M_mem_read, M_mem_write                 EX/MEM stage controls
//   WB_reg_write, WB_mem_to_reg             MEM/WB stage controls
//   pc_write, ifid_write, flush, jump,
//   branch_taken, stall                     combinational pipeline steering
// ---------------------------------------------------------------------------
interface pipe_ctrl_unit_if #(
   parameter int ALUOP_W = 3
);
   logic [31:0]        inst;
   logic               eq;
   logic               hold;
   logic               EX_alusrc;
   logic               EX_regdst;
   logic [ALUOP_W-1:0] EX_aluop;
   logic               M_mem_read;
   logic               M_mem_write;
   logic               WB_reg_write;
   logic               WB_mem_to_reg;
   logic               pc_write;
   logic               ifid_write;
   logic               flush;
   logic               jump;
   logic               branch_taken;
   logic               stall;

   modport master (
      output inst, eq, hold,
      input  EX_alusrc, EX_regdst, EX_aluop, M_mem_read, M_mem_write,
             WB_reg_write, WB_mem_to_reg, pc_write, ifid_write, flush,
             jump, branch_taken, stall
   );

   modport slave (
      input  inst, eq, hold,
      output EX_alusrc, EX_regdst, EX_aluop, M_mem_read, M_mem_write,
             WB_reg_write, WB_mem_to_reg, pc_write, ifid_write, flush,
             jump, branch_taken, stall
   );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit
// Pipelined MIPS control unit: decodes the ID-stage instruction, carries its
// controls through ID/EX, EX/MEM and MEM/WB, inserts LOAD_STALL bubbles on a
// load-use hazard, resolves beq/bne/j in ID (flushing IF/ID when taken) and
// freezes everything while hold is high.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - pipe_ctrl_unit_if.slave (inst/eq/hold in, stage controls and
//          steering signals out)
// Parameters:
//   LOAD_STALL - bubbles per load-use hazard (1..3)
//   ALUOP_W    - ALU op width; R-type aluop = inst[ALUOP_W-1:0]
// ---------------------------------------------------------------------------
module pipe_ctrl_unit #(
   parameter int LOAD_STALL = 1,
   parameter int ALUOP_W    = 3
) (
   input  logic            clk,
   input  logic            rst,
   pipe_ctrl_unit_if.slave bus
);
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
   // Hazard cycle itself is the first bubble, so STALL covers LOAD_STALL-1.
   localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 2);

   typedef enum logic {ST_RUN, ST_STALL} state_t;

   state_t             r_state;
   logic [1:0]         r_cnt;

   // ID/EX
   logic               r_ex_alusrc;
   logic               r_ex_regdst;
   logic [ALUOP_W-1:0] r_ex_aluop;
   logic               r_ex_mem_read;
   logic               r_ex_mem_write;
   logic               r_ex_reg_write;
   logic               r_ex_mem_to_reg;
   logic [4:0]         r_ex_rt;
   // EX/MEM
   logic               r_m_mem_read;
   logic               r_m_mem_write;
   logic               r_m_reg_write;
   logic               r_m_mem_to_reg;
   // MEM/WB
   logic               r_wb_reg_write;
   logic               r_wb_mem_to_reg;

   logic [5:0]         w_op;
   logic [4:0]         w_rs;
   logic [4:0]         w_rt;

   logic               w_dec_alusrc;
   logic               w_dec_regdst;
   logic [ALUOP_W-1:0] w_dec_aluop;
   logic               w_dec_mem_read;
   logic               w_dec_mem_write;
   logic               w_dec_reg_write;
   logic               w_dec_mem_to_reg;
   logic               w_use_rs;
   logic               w_use_rt;
   logic               w_is_beq;
   logic               w_is_bne;
   logic               w_is_j;

   logic               w_hazard;
   logic               w_taken;
   logic               w_stall;
   logic               w_pc_write;
   logic               w_ifid_write;
   logic               w_flush;
   logic               w_jump;
   logic               w_branch_taken;

   assign w_op = bus.inst[31:26];
   assign w_rs = bus.inst[25:21];
   assign w_rt = bus.inst[20:16];

   // Instruction decode, including which source registers are actually read.
   always_comb begin
      w_dec_alusrc     = 1'b0;
      w_dec_regdst     = 1'b0;
      w_dec_aluop      = '0;
      w_dec_mem_read   = 1'b0;
      w_dec_mem_write  = 1'b0;
      w_dec_reg_write  = 1'b0;
      w_dec_mem_to_reg = 1'b0;
      w_use_rs         = 1'b0;
      w_use_rt         = 1'b0;
      w_is_beq         = 1'b0;
      w_is_bne         = 1'b0;
      w_is_j           = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            // An all-zero word is the canonical nop and drives nothing.
            if (bus.inst != 32'd0) begin
               w_dec_regdst    = 1'b1;
               w_dec_reg_write = 1'b1;
               w_dec_aluop     = bus.inst[ALUOP_W-1:0];
               w_use_rs        = 1'b1;
               w_use_rt        = 1'b1;
            end
         end
         OP_LW: begin
            w_dec_alusrc     = 1'b1;
            w_dec_aluop      = ALU_ADD;
            w_dec_mem_read   = 1'b1;
            w_dec_reg_write  = 1'b1;
            w_dec_mem_to_reg = 1'b1;
            w_use_rs         = 1'b1;
         end
         OP_SW: begin
            w_dec_alusrc    = 1'b1;
            w_dec_aluop     = ALU_ADD;
            w_dec_mem_write = 1'b1;
            w_use_rs        = 1'b1;
            w_use_rt        = 1'b1;
         end
         OP_ADDI: begin
            w_dec_alusrc    = 1'b1;
            w_dec_aluop     = ALU_ADD;
            w_dec_reg_write = 1'b1;
            w_use_rs        = 1'b1;
         end
         OP_BEQ: begin
            w_is_beq = 1'b1;
            w_use_rs = 1'b1;
            w_use_rt = 1'b1;
         end
         OP_BNE: begin
            w_is_bne = 1'b1;
            w_use_rs = 1'b1;
            w_use_rt = 1'b1;
         end
         OP_J: begin
            w_is_j = 1'b1;
         end
         default: ;
      endcase
   end

   // $0 never carries a real dependency, so a load into $0 cannot hazard.
   assign w_hazard = r_ex_mem_read && (r_ex_rt != 5'd0) &&
                     ((w_use_rs && (r_ex_rt == w_rs)) ||
                      (w_use_rt && (r_ex_rt == w_rt)));

   assign w_taken = (w_is_beq && bus.eq) || (w_is_bne && !bus.eq) || w_is_j;

   // Pipeline steering. hold silences everything; a bubble cycle blocks
   // fetch and suppresses any branch/jump still waiting in ID.
   always_comb begin
      w_stall        = 1'b0;
      w_pc_write     = 1'b0;
      w_ifid_write   = 1'b0;
      w_flush        = 1'b0;
      w_jump         = 1'b0;
      w_branch_taken = 1'b0;
      if (!bus.hold) begin
         if ((r_state == ST_STALL) || w_hazard) begin
            w_stall = 1'b1;
         end else begin
            w_pc_write     = 1'b1;
            w_ifid_write   = 1'b1;
            w_flush        = w_taken;
            w_branch_taken = w_taken;
            w_jump         = w_is_j;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_RUN;
         r_cnt           <= 2'd0;
         r_ex_alusrc     <= 1'b0;
         r_ex_regdst     <= 1'b0;
         r_ex_aluop      <= '0;
         r_ex_mem_read   <= 1'b0;
         r_ex_mem_write  <= 1'b0;
         r_ex_reg_write  <= 1'b0;
         r_ex_mem_to_reg <= 1'b0;
         r_ex_rt         <= 5'd0;
         r_m_mem_read    <= 1'b0;
         r_m_mem_write   <= 1'b0;
         r_m_reg_write   <= 1'b0;
         r_m_mem_to_reg  <= 1'b0;
         r_wb_reg_write  <= 1'b0;
         r_wb_mem_to_reg <= 1'b0;
      end else if (!bus.hold) begin
         r_m_mem_read    <= r_ex_mem_read;
         r_m_mem_write   <= r_ex_mem_write;
         r_m_reg_write   <= r_ex_reg_write;
         r_m_mem_to_reg  <= r_ex_mem_to_reg;
         r_wb_reg_write  <= r_m_reg_write;
         r_wb_mem_to_reg <= r_m_mem_to_reg;

         if (w_stall) begin
            r_ex_alusrc     <= 1'b0;
            r_ex_regdst     <= 1'b0;
            r_ex_aluop      <= '0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
            r_ex_rt         <= 5'd0;
         end else begin
            r_ex_alusrc     <= w_dec_alusrc;
            r_ex_regdst     <= w_dec_regdst;
            r_ex_aluop      <= w_dec_aluop;
            r_ex_mem_read   <= w_dec_mem_read;
            r_ex_mem_write  <= w_dec_mem_write;
            r_ex_reg_write  <= w_dec_reg_write;
            r_ex_mem_to_reg <= w_dec_mem_to_reg;
            r_ex_rt         <= w_rt;
         end

         case (r_state)
            ST_RUN: begin
               if (w_hazard && (LOAD_STALL > 1)) begin
                  r_state <= ST_STALL;
                  r_cnt   <= STALL_INIT;
               end
            end
            ST_STALL: begin
               if (r_cnt == 2'd0) begin
                  r_state <= ST_RUN;
               end else begin
                  r_cnt <= r_cnt - 2'd1;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign bus.EX_alusrc     = r_ex_alusrc;
   assign bus.EX_regdst     = r_ex_regdst;
   assign bus.EX_aluop      = r_ex_aluop;
   assign bus.M_mem_read    = r_m_mem_read;
   assign bus.M_mem_write   = r_m_mem_write;
   assign bus.WB_reg_write  = r_wb_reg_write;
   assign bus.WB_mem_to_reg = r_wb_mem_to_reg;
   assign bus.pc_write      = w_pc_write;
   assign bus.ifid_write    = w_ifid_write;
   assign bus.flush         = w_flush;
   assign bus.jump          = w_jump;
   assign bus.branch_taken  = w_branch_taken;
   assign bus.stall         = w_stall;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_unit
// Two controllers (LOAD_STALL=1 and LOAD_STALL=2) exercised one after the
// other. The bench plays the fetch stage from a small program, predicts the
// controls each instruction should load into ID/EX, queues that prediction
// and retires it through EX, MEM and WB as the DUT advances.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_unit;
   typedef struct packed {
      logic       alusrc;
      logic       regdst;
      logic [2:0] aluop;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic [4:0] rt;
   } ctl_t;

   typedef struct packed {
      logic [31:0] inst;
      logic        eq;
      logic        hold3;   // freeze 3 cycles the first time this sits in ID
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0;
   always #5 clk = ~clk;

   pipe_ctrl_unit_if #(.ALUOP_W(3)) if1 ();
   pipe_ctrl_unit_if #(.ALUOP_W(3)) if2 ();

   pipe_ctrl_unit #(.LOAD_STALL(1), .ALUOP_W(3)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   pipe_ctrl_unit #(.LOAD_STALL(2), .ALUOP_W(3)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (if2.slave)
   );

   logic [4:0] obs_ex;
   logic [1:0] obs_m;
   logic [1:0] obs_wb;
   logic [5:0] obs_comb;

   always_comb begin
      if (sel) begin
         obs_ex   = {if2.EX_alusrc, if2.EX_regdst, if2.EX_aluop};
         obs_m    = {if2.M_mem_read, if2.M_mem_write};
         obs_wb   = {if2.WB_reg_write, if2.WB_mem_to_reg};
         obs_comb = {if2.stall, if2.pc_write, if2.ifid_write, if2.flush,
                     if2.jump, if2.branch_taken};
      end else begin
         obs_ex   = {if1.EX_alusrc, if1.EX_regdst, if1.EX_aluop};
         obs_m    = {if1.M_mem_read, if1.M_mem_write};
         obs_wb   = {if1.WB_reg_write, if1.WB_mem_to_reg};
         obs_comb = {if1.stall, if1.pc_write, if1.ifid_write, if1.flush,
                     if1.jump, if1.branch_taken};
      end
   end

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc_g = 0;
   ent_t prog[$];
   ctl_t q_id[$];
   ctl_t cur_ex, cur_m, cur_wb;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc_g, got, exp);
      end
   endtask

   // Unselected controller is frozen so it stays out of the way.
   task automatic drive(input logic [31:0] i, input logic e, input logic h);
      if (sel) begin
         if2.inst = i;  if2.eq = e;  if2.hold = h;
         if1.inst = '0; if1.eq = 1'b0; if1.hold = 1'b1;
      end else begin
         if1.inst = i;  if1.eq = e;  if1.hold = h;
         if2.inst = '0; if2.eq = 1'b0; if2.hold = 1'b1;
      end
   endtask

   function automatic ctl_t dec(input logic [31:0] i);
      ctl_t c;
      c = '0;
      case (i[31:26])
         6'b000000: if (i != 32'd0) begin
            c.regdst = 1'b1; c.reg_write = 1'b1; c.aluop = i[2:0];
         end
         6'b100011: begin
            c.alusrc = 1'b1; c.aluop = 3'b010; c.mem_read = 1'b1;
            c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
         end
         6'b101011: begin c.alusrc = 1'b1; c.aluop = 3'b010; c.mem_write = 1'b1; end
         6'b001000: begin c.alusrc = 1'b1; c.aluop = 3'b010; c.reg_write = 1'b1; end
         default: ;
      endcase
      c.rt = i[20:16];
      return c;
   endfunction

   function automatic logic uses_rs(input logic [31:0] i);
      logic [5:0] op;
      op = i[31:26];
      return (op == 6'b000000 && i != 32'd0) || op == 6'b100011 || op == 6'b101011 ||
             op == 6'b001000 || op == 6'b000100 || op == 6'b000101;
   endfunction

   function automatic logic uses_rt(input logic [31:0] i);
      logic [5:0] op;
      op = i[31:26];
      return (op == 6'b000000 && i != 32'd0) || op == 6'b101011 ||
             op == 6'b000100 || op == 6'b000101;
   endfunction

   function automatic ent_t fetch(input int pc);
      ent_t e;
      e = '0;
      if (pc < prog.size()) e = prog[pc];
      return e;
   endfunction

   task automatic run_phase(input string name, input logic s, input int ls, input int ncyc);
      ent_t       id;
      ctl_t       d, exp_load;
      logic [5:0] exp_comb;
      logic       h, hz, tk, hold_done;
      int         pc, m_rem, hold_left;

      sel = s;
      id = fetch(0);
      pc = 1;
      m_rem = 0;
      hold_left = 0;
      hold_done = 1'b0;
      cur_ex = '0; cur_m = '0; cur_wb = '0;
      q_id.delete();

      rst = 1'b1;
      drive(id.inst, id.eq, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk({name, ".rst_ex"}, 8'(obs_ex), 8'd0);
      chk({name, ".rst_m"},  8'(obs_m),  8'd0);
      chk({name, ".rst_wb"}, 8'(obs_wb), 8'd0);
      rst = 1'b0;

      for (int c = 0; c < ncyc; c++) begin
         cyc_g = c;
         if (!hold_done && id.hold3 && hold_left == 0) begin
            hold_left = 3;
            hold_done = 1'b1;
         end
         h = (hold_left > 0);

         exp_comb = '0;
         exp_load = '0;
         hz = 1'b0;
         if (!h) begin
            if (m_rem > 0) begin
               exp_comb[5] = 1'b1;
            end else begin
               d  = dec(id.inst);
               hz = cur_ex.mem_read && cur_ex.rt != 5'd0 &&
                    ((uses_rs(id.inst) && cur_ex.rt == id.inst[25:21]) ||
                     (uses_rt(id.inst) && cur_ex.rt == id.inst[20:16]));
               if (hz) begin
                  exp_comb[5] = 1'b1;
               end else begin
                  tk = (id.inst[31:26] == 6'b000100 &&  id.eq) ||
                       (id.inst[31:26] == 6'b000101 && !id.eq) ||
                       (id.inst[31:26] == 6'b000010);
                  exp_load    = d;
                  exp_comb[4] = 1'b1;
                  exp_comb[3] = 1'b1;
                  exp_comb[2] = tk;
                  exp_comb[1] = (id.inst[31:26] == 6'b000010);
                  exp_comb[0] = tk;
               end
            end
         end

         drive(id.inst, id.eq, h);
         if (!h) q_id.push_back(exp_load);

         @(negedge clk);
         chk({name, ".comb"}, 8'(obs_comb), 8'(exp_comb));
         chk({name, ".ex"}, 8'(obs_ex), 8'({cur_ex.alusrc, cur_ex.regdst, cur_ex.aluop}));
         chk({name, ".m"},  8'(obs_m),  8'({cur_m.mem_read, cur_m.mem_write}));
         chk({name, ".wb"}, 8'(obs_wb), 8'({cur_wb.reg_write, cur_wb.mem_to_reg}));
         $display("%s c%0d id=%08h eq=%0b hold=%0b comb=%06b ex=%05b m=%02b wb=%02b",
                  name, c, id.inst, id.eq, h, obs_comb, obs_ex, obs_m, obs_wb);

         @(posedge clk);
         #1;
         if (h) begin
            hold_left--;
         end else begin
            cur_wb = cur_m;
            cur_m  = cur_ex;
            cur_ex = q_id.pop_front();
            if (m_rem > 0) m_rem--;
            else if (hz) m_rem = ls - 1;
            if (exp_comb[3]) begin
               if (exp_comb[2]) begin
                  id = '0;
               end else begin
                  id = fetch(pc);
                  pc++;
               end
            end
         end
      end
   endtask

   initial begin
      drive(32'd0, 1'b0, 1'b0);

      // LOAD_STALL=1: load-use, lui/nop, hold over taken beq, branches, jump
      prog.delete();
      prog.push_back('{32'h8D090000, 1'b0, 1'b0});
      prog.push_back('{32'h012B5020, 1'b0, 1'b0});
      prog.push_back('{32'h3C010001, 1'b0, 1'b0});
      prog.push_back('{32'h00000000, 1'b0, 1'b0});
      prog.push_back('{32'h8D0A0000, 1'b0, 1'b0});
      prog.push_back('{32'h10220003, 1'b1, 1'b1});
      prog.push_back('{32'h14220003, 1'b1, 1'b0});
      prog.push_back('{32'h14220003, 1'b0, 1'b0});
      prog.push_back('{32'h08000010, 1'b0, 1'b0});
      prog.push_back('{32'h10220003, 1'b0, 1'b0});
      prog.push_back('{32'h20010005, 1'b0, 1'b0});
      run_phase("ls1", 1'b0, 1, 26);

      // LOAD_STALL=2: rs and rt hazards, load into $0, branch behind a load
      prog.delete();
      prog.push_back('{32'h8D090000, 1'b0, 1'b0});
      prog.push_back('{32'h012B5020, 1'b0, 1'b0});
      prog.push_back('{32'h8D090000, 1'b0, 1'b0});
      prog.push_back('{32'hAD090004, 1'b0, 1'b0});
      prog.push_back('{32'h8D000000, 1'b0, 1'b0});
      prog.push_back('{32'h00005020, 1'b0, 1'b0});
      prog.push_back('{32'h8D090000, 1'b0, 1'b0});
      prog.push_back('{32'h11220003, 1'b1, 1'b0});
      prog.push_back('{32'h0128502A, 1'b0, 1'b0});
      run_phase("ls2", 1'b1, 2, 24);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised, pipelined successor to the single-stage MIPS decoder. Decodes the ID-stage instruction, carries its control bits through internal ID/EX, EX/MEM and MEM/WB registers, detects load-use hazards with a configurable stall length, resolves beq/bne/j in ID with IF/ID flush, and honours an external pipeline freeze. Sits between the IF/ID register and the datapath stage registers.

## Interface
- LOAD_STALL, 1, bubbles inserted per load-use hazard; legal 1..3 (2 when no MEM->EX forwarding).
- ALUOP_W, 3, ALU op width; R-type aluop = inst[ALUOP_W-1:0].
- clk  in  1  clock; one clock domain, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst  in  32  instruction in ID (IF/ID register output).
- eq  in  1  ID register comparator result (rs == rt).
- hold  in  1  freeze whole pipeline (e.g. memory busy).
- EX_alusrc, EX_regdst  out  1  registered, ID/EX stage.
- EX_aluop  out  ALUOP_W  registered, ID/EX stage.
- M_mem_read, M_mem_write  out  1  registered, EX/MEM stage.
- WB_reg_write, WB_mem_to_reg  out  1  registered, MEM/WB stage.
- pc_write, ifid_write  out  1  combinational; 0 = hold PC / IF/ID.
- flush  out  1  combinational; IF/ID loads a bubble next edge.
- jump, branch_taken  out  1  combinational PC-source selects.
- stall  out  1  combinational; bubble inserted into ID/EX this cycle.

## Operation
- Decode (opcode inst[31:26]): 000000 R-type: regdst=1, reg_write=1, aluop=inst[ALUOP_W-1:0]; inst==0 is nop (all controls 0). 100011 lw: alusrc, aluop=010, mem_read, reg_write, mem_to_reg. 101011 sw: alusrc, aluop=010, mem_write. 001000 addi: alusrc, aluop=010, reg_write. 000100 beq: taken=eq. 000101 bne: taken=~eq. 000010 j: jump, taken. Any other opcode: all controls 0, no flush.
- Source use: rs=inst[25:21] read by R, lw, sw, addi, beq, bne; rt=inst[20:16] read by R, sw, beq, bne; j reads none.
- Internal ex_rt register captures inst[20:16] alongside ID/EX controls.
- Hazard = ID/EX mem_read && ex_rt != 0 && (ex_rt == used rs || ex_rt == used rt).
- FSM RUN/STALL plus 2-bit counter cnt:
  - RUN, hazard: stall=1, pc_write=0, ifid_write=0, ID/EX loads zeros; branch/jump suppressed (flush=0, jump=0, branch_taken=0). If LOAD_STALL>1 -> STALL, cnt=LOAD_STALL-2; else stay RUN.
  - STALL: same outputs as hazard cycle; cnt==0 -> RUN, else cnt-1.
  - RUN, no hazard: pc_write=1, ifid_write=1, ID/EX loads decoded controls; taken branch or j -> flush=1 with branch_taken/jump.
- hold=1 (priority over all but rst): every pipeline register, state and cnt keep value; pc_write=0, ifid_write=0, flush=0, jump=0, branch_taken=0, stall=0.
- EX/MEM and MEM/WB always advance from the previous stage unless hold.

## Timing
- Reset: every registered output 0, ex_rt=0, state RUN, cnt=0; combinational outputs then follow inst/eq.
- rst during STALL or hold: next cycle state RUN, all stages bubbles.
- Instruction decoded in ID at cycle n: EX_* valid n+1, M_* n+2, WB_* n+3 (no hold/stall).
- Load-use: dependent instruction leaves ID exactly LOAD_STALL cycles later than otherwise.
- Branch/jump: decided same cycle in ID; one-cycle penalty (flush) when taken, none when not taken.
- Branch behind load hazard: taken evaluated only in the first non-stall cycle.
- hold and taken branch same cycle: no flush; re-evaluated when hold drops.

## Test plan
- Reset: rst=1 two cycles with inst=0x8D090000 -> all registered outputs 0; release -> EX_alusrc=1, EX_aluop=010 next cycle, M_mem_read=1 at +2, WB_mem_to_reg=1 at +3.
- Load-use, LOAD_STALL=1: 0x8D090000 then 0x012B5020 -> one cycle stall=1, pc_write=0, ifid_write=0, EX_* zero; add reaches EX next cycle with EX_regdst=1, EX_aluop=000.
- Load-use, LOAD_STALL=2: same pair -> exactly 2 stall cycles; lw then 0xAD090004 (sw rt=9) also stalls 2; lw with rt=0 (0x8D000000) then add using $0 -> no stall.
- Branch: 0x10220003 eq=1 -> flush=1, branch_taken=1; eq=0 -> flush=0; bne 0x14220003 eq=0 -> flush=1; j 0x08000010 -> jump=1, flush=1.
- Hold: hold=1 for 3 cycles mid-stream with beq eq=1 in ID -> all stage outputs frozen, pc_write=0, flush=0; hold=0 -> flush=1 that cycle.
- Unknown opcode 0x3C010001 (lui) and inst=0 -> all controls 0, no stall, no flush, WB_reg_write=0 at +3.
